uart_rx_frontend: RTL

- RS-232 8N1 receiver feeding the 10K-bit receive chain.
- Oversamples serial line `rxd` at 16x baud on `rcvbuf_clk`.
- Assembles each byte LSB-first into `rbr` and raises `newdata`; holds both until the downstream receive buffer returns `ack`.
- Flags framing errors, and flags overrun when a byte completes while the downstream is not ready.

---
 rtl/uart_rx_frontend_if.sv | 20 ++
 rtl/uart_rx_frontend.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend_if.sv
// Receiver-side bundle: serial line in, byte/handshake/status to the receive buffer.
// UART_RX_PARITY_EN adds the parity_err status line.
interface uart_rx_frontend_if #(parameter int DATA_BITS = 8);
   logic                 rxd;
   logic                 ack;
   logic                 rfd;
   logic [DATA_BITS-1:0] rbr;
   logic                 newdata;
   logic                 framing_err;
   logic                 overrun;
`ifdef UART_RX_PARITY_EN
   logic                 parity_err;

   modport master (input rxd, ack, rfd, output rbr, newdata, framing_err, overrun, parity_err);
   modport slave  (output rxd, ack, rfd, input rbr, newdata, framing_err, overrun, parity_err);
`else
   modport master (input rxd, ack, rfd, output rbr, newdata, framing_err, overrun);
   modport slave  (output rxd, ack, rfd, input rbr, newdata, framing_err, overrun);
`endif
endinterface

// File: rtl/uart_rx_frontend.sv
// 16x-oversampled 8N1 UART receiver with newdata/ack handshake, framing and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx_frontend #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input logic                rcvbuf_clk,
   input logic                reset,
   uart_rx_frontend_if.master bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

   state_t               state, state_nx;
   logic                 sync1, rxd_s;
   logic [CW-1:0]        cnt, cnt_nx;
   logic [IW-1:0]        idx, idx_nx;
   logic [DATA_BITS-1:0] shift, shift_nx;
   logic [DATA_BITS-1:0] rbr_q, rbr_nx;
   logic                 nd_q, nd_nx;
   logic                 ferr_q, ferr_nx;
   logic                 ovr_q, ovr_nx;
   logic                 keep;

`ifdef UART_RX_PARITY_EN
   logic perr_q, perr_nx, pbad_q, pbad_nx;
   assign keep = ~pbad_q;
`else
   assign keep = 1'b1;
`endif

   always_ff @(posedge rcvbuf_clk or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b1;
         rxd_s  <= 1'b1;
         state  <= S_IDLE;
         cnt    <= '0;
         idx    <= '0;
         shift  <= '0;
         rbr_q  <= '0;
         nd_q   <= 1'b0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q <= 1'b0;
         pbad_q <= 1'b0;
`endif
      end else begin
         sync1  <= bus.rxd;
         rxd_s  <= sync1;
         state  <= state_nx;
         cnt    <= cnt_nx;
         idx    <= idx_nx;
         shift  <= shift_nx;
         rbr_q  <= rbr_nx;
         nd_q   <= nd_nx;
         ferr_q <= ferr_nx;
         ovr_q  <= ovr_nx;
`ifdef UART_RX_PARITY_EN
         perr_q <= perr_nx;
         pbad_q <= pbad_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      shift_nx = shift;
      rbr_nx   = rbr_q;
      nd_nx    = nd_q & ~bus.ack;
      ferr_nx  = 1'b0;
      ovr_nx   = ovr_q;
`ifdef UART_RX_PARITY_EN
      perr_nx  = 1'b0;
      pbad_nx  = pbad_q;
`endif
      case (state)
         S_IDLE: begin
            cnt_nx = '0;
            idx_nx = '0;
`ifdef UART_RX_PARITY_EN
            pbad_nx = 1'b0;
`endif
            if (!rxd_s) state_nx = S_START;
         end
         S_START: begin
            if (cnt == CNT_MID) begin
               cnt_nx   = '0;
               idx_nx   = '0;
               state_nx = rxd_s ? S_IDLE : S_DATA;
            end else cnt_nx = cnt + 1'b1;
         end
         S_DATA: begin
            // LSB arrives first, so shifting right leaves bit 0 in shift[0]
            if (cnt == CNT_END) begin
               cnt_nx   = '0;
               shift_nx = {rxd_s, shift[DATA_BITS-1:1]};
               if (idx == IDX_LAST) begin
                  idx_nx = '0;
`ifdef UART_RX_PARITY_EN
                  state_nx = S_PARITY;
`else
                  state_nx = S_STOP;
`endif
               end else idx_nx = idx + 1'b1;
            end else cnt_nx = cnt + 1'b1;
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt == CNT_END) begin
               cnt_nx   = '0;
               pbad_nx  = (^shift) != rxd_s;
               perr_nx  = (^shift) != rxd_s;
               state_nx = S_STOP;
            end else cnt_nx = cnt + 1'b1;
         end
`endif
         S_STOP: begin
            // sampled at mid stop bit so IDLE is back in time for a back-to-back start edge
            if (cnt == CNT_END) begin
               cnt_nx = '0;
               if (!rxd_s) begin
                  ferr_nx  = 1'b1;
                  state_nx = S_BREAK;
               end else begin
                  state_nx = S_IDLE;
                  if (keep) begin
                     if (bus.rfd && !nd_q) begin
                        rbr_nx = shift;
                        nd_nx  = 1'b1;
                        ovr_nx = 1'b0;
                     end else ovr_nx = 1'b1;
                  end
               end
            end else cnt_nx = cnt + 1'b1;
         end
         S_BREAK: if (rxd_s) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.rbr         = rbr_q;
   assign bus.newdata     = nd_q;
   assign bus.framing_err = ferr_q;
   assign bus.overrun     = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err  = perr_q;
`endif
endmodule
